// File: rtl/tic_tac_toe_board_if.sv
// tic_tac_toe_board_if: move request inputs (new_game, play, playX_en, play0_en, pos) and board status outputs (board_x, board_o, win, nospc, move_cnt, illegal)
interface tic_tac_toe_board_if;
  logic       new_game;
  logic       play;
  logic       playX_en;
  logic       play0_en;
  logic [3:0] pos;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic [1:0] win;
  logic       nospc;
  logic [3:0] move_cnt;
  logic       illegal;
  modport master (
    output new_game, play, playX_en, play0_en, pos,
    input  board_x, board_o, win, nospc, move_cnt, illegal
  );
  modport slave (
    input  new_game, play, playX_en, play0_en, pos,
    output board_x, board_o, win, nospc, move_cnt, illegal
  );
endinterface

// File: rtl/tic_tac_toe_board.sv
// tic_tac_toe_board: 3x3 board register with move validation, win/draw detection and illegal-move pulse; ports clk, rst, bus (slave)
module tic_tac_toe_board (
  input logic               clk,
  input logic               rst,
  tic_tac_toe_board_if.slave bus
);
  logic [8:0] sel, occ, nx_x, nx_o;
  logic [3:0] nx_cnt;
  logic [1:0] nx_win;
  logic       attempt, both, accept;
  function automatic logic line_full(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction
  always_comb begin
    sel     = 9'b1 << bus.pos;
    occ     = bus.board_x | bus.board_o;
    attempt = bus.play & (bus.playX_en ^ bus.play0_en);
    both    = bus.play & bus.playX_en & bus.play0_en;
    accept  = attempt & (|sel) & ~(|(sel & occ)) & (bus.win == 2'b00);
    nx_x    = bus.board_x | ((accept & bus.playX_en) ? sel : 9'b0);
    nx_o    = bus.board_o | ((accept & bus.play0_en) ? sel : 9'b0);
    nx_cnt  = bus.move_cnt + {3'b0, accept};
    nx_win  = line_full(nx_x) ? 2'b01 : line_full(nx_o) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      bus.board_x  <= '0;
      bus.board_o  <= '0;
      bus.move_cnt <= '0;
      bus.win      <= 2'b00;
      bus.nospc    <= 1'b0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.board_x  <= nx_x;
      bus.board_o  <= nx_o;
      bus.move_cnt <= nx_cnt;
      bus.win      <= nx_win;
      bus.nospc    <= nx_cnt == 4'd9;
      bus.illegal  <= both | (attempt & ~accept);
    end
  end
endmodule

// File: tb/tb_tic_tac_toe_board.sv
// tb_tic_tac_toe_board: scoreboard bench driving directed moves and checking board state each cycle
module tb_tic_tac_toe_board;
  typedef struct packed {
    logic [8:0] bx;
    logic [8:0] bo;
    logic [1:0] w;
    logic       ns;
    logic [3:0] c;
    logic       il;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t  exp_q[$];
  string name_q[$];
  tic_tac_toe_board_if bus();
  tic_tac_toe_board dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic v(input string n, input logic r, input logic ng, input logic p,
                   input logic xe, input logic oe, input logic [3:0] ps,
                   input logic [8:0] ex, input logic [8:0] eo, input logic [1:0] ew,
                   input logic ens, input logic [3:0] ec, input logic eil);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.new_game = ng;
    bus.play = p;
    bus.playX_en = xe;
    bus.play0_en = oe;
    bus.pos = ps;
    e = '{bx: ex, bo: eo, w: ew, ns: ens, c: ec, il: eil};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{bx: bus.board_x, bo: bus.board_o, w: bus.win, ns: bus.nospc, c: bus.move_cnt, il: bus.illegal};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got x=%h o=%h win=%b nospc=%b cnt=%0d ill=%b, expected x=%h o=%h win=%b nospc=%b cnt=%0d ill=%b",
                 n, a.bx, a.bo, a.w, a.ns, a.c, a.il, e.bx, e.bo, e.w, e.ns, e.c, e.il);
      end
    end
  end
  initial begin
    bus.new_game = 0;
    bus.play = 0;
    bus.playX_en = 0;
    bus.play0_en = 0;
    bus.pos = 0;
    v("reset",        1,0,1,1,0,4'd0, 9'h000,9'h000,2'b00,0,4'd0,0);
    v("row_x0",       0,0,1,1,0,4'd0, 9'h001,9'h000,2'b00,0,4'd1,0);
    v("row_o3",       0,0,1,0,1,4'd3, 9'h001,9'h008,2'b00,0,4'd2,0);
    v("row_x1",       0,0,1,1,0,4'd1, 9'h003,9'h008,2'b00,0,4'd3,0);
    v("row_o4",       0,0,1,0,1,4'd4, 9'h003,9'h018,2'b00,0,4'd4,0);
    v("row_x2_win",   0,0,1,1,0,4'd2, 9'h007,9'h018,2'b01,0,4'd5,0);
    v("row_frozen",   0,0,1,0,1,4'd5, 9'h007,9'h018,2'b01,0,4'd5,1);
    v("row_idle",     0,0,0,0,0,4'd0, 9'h007,9'h018,2'b01,0,4'd5,0);
    v("newgame_move", 0,1,1,1,0,4'd8, 9'h000,9'h000,2'b00,0,4'd0,0);
    v("occ_x4",       0,0,1,1,0,4'd4, 9'h010,9'h000,2'b00,0,4'd1,0);
    v("occ_o4",       0,0,1,0,1,4'd4, 9'h010,9'h000,2'b00,0,4'd1,1);
    v("occ_idle",     0,0,0,0,0,4'd0, 9'h010,9'h000,2'b00,0,4'd1,0);
    v("pos9",         0,0,1,1,0,4'd9, 9'h010,9'h000,2'b00,0,4'd1,1);
    v("both_en",      0,0,1,1,1,4'd0, 9'h010,9'h000,2'b00,0,4'd1,1);
    v("no_en",        0,0,1,0,0,4'd0, 9'h010,9'h000,2'b00,0,4'd1,0);
    v("pos15",        0,0,1,0,1,4'd15,9'h010,9'h000,2'b00,0,4'd1,1);
    v("newgame",      0,1,0,0,0,4'd0, 9'h000,9'h000,2'b00,0,4'd0,0);
    v("draw_x0",      0,0,1,1,0,4'd0, 9'h001,9'h000,2'b00,0,4'd1,0);
    v("draw_o1",      0,0,1,0,1,4'd1, 9'h001,9'h002,2'b00,0,4'd2,0);
    v("draw_x2",      0,0,1,1,0,4'd2, 9'h005,9'h002,2'b00,0,4'd3,0);
    v("draw_o4",      0,0,1,0,1,4'd4, 9'h005,9'h012,2'b00,0,4'd4,0);
    v("draw_x3",      0,0,1,1,0,4'd3, 9'h00D,9'h012,2'b00,0,4'd5,0);
    v("draw_o5",      0,0,1,0,1,4'd5, 9'h00D,9'h032,2'b00,0,4'd6,0);
    v("draw_x7",      0,0,1,1,0,4'd7, 9'h08D,9'h032,2'b00,0,4'd7,0);
    v("draw_o6",      0,0,1,0,1,4'd6, 9'h08D,9'h072,2'b00,0,4'd8,0);
    v("draw_x8_full", 0,0,1,1,0,4'd8, 9'h18D,9'h072,2'b00,1,4'd9,0);
    v("draw_extra",   0,0,1,0,1,4'd0, 9'h18D,9'h072,2'b00,1,4'd9,1);
    v("newgame2",     0,1,0,0,0,4'd0, 9'h000,9'h000,2'b00,0,4'd0,0);
    v("diag_x0",      0,0,1,1,0,4'd0, 9'h001,9'h000,2'b00,0,4'd1,0);
    v("diag_o2",      0,0,1,0,1,4'd2, 9'h001,9'h004,2'b00,0,4'd2,0);
    v("diag_x1",      0,0,1,1,0,4'd1, 9'h003,9'h004,2'b00,0,4'd3,0);
    v("diag_o4",      0,0,1,0,1,4'd4, 9'h003,9'h014,2'b00,0,4'd4,0);
    v("diag_x5",      0,0,1,1,0,4'd5, 9'h023,9'h014,2'b00,0,4'd5,0);
    v("diag_o6_win",  0,0,1,0,1,4'd6, 9'h023,9'h054,2'b10,0,4'd6,0);
    v("diag_frozen",  0,0,1,1,0,4'd8, 9'h023,9'h054,2'b10,0,4'd6,1);
    v("rst_midgame",  1,0,1,1,0,4'd8, 9'h000,9'h000,2'b00,0,4'd0,0);
    v("post_rst_x8",  0,0,1,1,0,4'd8, 9'h100,9'h000,2'b00,0,4'd1,0);
    v("final_idle",   0,0,0,0,0,4'd0, 9'h100,9'h000,2'b00,0,4'd1,0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tic_tac_toe_board.md
TIC_TAC_TOE_BOARD -- requirements
Module: tic_tac_toe_board

Interface
REQ-001 Parameters: none; board fixed at 9 cells, row-major index 0..8, cell 0 top-left.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 new_game  input  1  synchronous board clear request.
REQ-005 play  input  1  move strobe, sampled each rising edge; same strobe the turn controller uses.
REQ-006 playX_en  input  1  X-turn enable from the turn controller.
REQ-007 play0_en  input  1  O-turn enable from the turn controller.
REQ-008 pos  input  4  target cell index for the move; valid range 0..8.
REQ-009 board_x  output  9  bit i set = cell i holds X.
REQ-010 board_o  output  9  bit i set = cell i holds O.
REQ-011 win  output  2  2'b00 none, 2'b01 X wins, 2'b10 O wins; 2'b11 never driven.
REQ-012 nospc  output  1  high while all 9 cells are occupied.
REQ-013 move_cnt  output  4  number of occupied cells, 0..9.
REQ-014 illegal  output  1  one-cycle pulse flagging a rejected move attempt.

Function
REQ-015 A move attempt is an edge where play=1 and playX_en XOR play0_en = 1.
REQ-016 Accepted move: attempt with pos<=8, cell pos empty in both boards, win==2'b00; sets board_x[pos] if playX_en, else board_o[pos], at that same edge.
REQ-017 Accepted move increments move_cnt by 1 at the same edge; move_cnt never exceeds 9 and never wraps.
REQ-018 win and nospc are registered from the next-state board: visible the cycle after the accepting edge, with the board update (latency 1).
REQ-019 Win lines: {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}; win=01 if any line full in board_x, else 10 if any line full in board_o, else 00.
REQ-020 Once win!=00, board, win, move_cnt are frozen until new_game or rst.
REQ-021 nospc = (move_cnt==9); a winning ninth move asserts both win and nospc in the same cycle.
REQ-022 Rejected attempt (pos>8, cell occupied, or win!=00): no state change except illegal=1 for exactly the next cycle.
REQ-023 play=1 with both enables high: no state change, illegal=1 for the next cycle.
REQ-024 play=1 with both enables low: ignored, illegal stays 0 (IDLE/game-over states of the controller).
REQ-025 Consecutive-cycle attempts are each evaluated independently against the board state from the prior edge.
REQ-026 new_game=1: board_x, board_o, move_cnt cleared, win=00, nospc=0, illegal=0 at that edge; any simultaneous move attempt is discarded.
REQ-027 Priority at an edge: rst > new_game > move attempt.
REQ-028 Board cells are never overwritten; a set bit clears only via new_game or rst.

Reset
REQ-029 rst=1 at a rising edge: board_x=0, board_o=0, move_cnt=0, win=00, nospc=0, illegal=0 after that edge.
REQ-030 rst asserted mid-game discards the board and any move sampled at the same edge; inputs ignored while rst=1.

Verification
REQ-031 X row: after rst, alternate X@0, O@3, X@1, O@4, X@2 -> win=01 the cycle after X@2, move_cnt=5, board_x=9'b000000111.
REQ-032 Occupied cell: X@4 then O@4 -> illegal=1 one cycle, board_o=0, move_cnt=1.
REQ-033 Out-of-range/both-enables: pos=9 with playX_en -> illegal pulse, no change; pos=0 with both enables -> illegal pulse, no change.
REQ-034 Draw: fill X@0,O@1,X@2,O@4,X@3,O@5,X@7,O@6,X@8 -> nospc=1, win=00, move_cnt=9; further attempt -> illegal pulse.
REQ-035 Freeze after win: O diagonal 2,4,6 reaches win=10; next attempt X@8 -> illegal pulse, board unchanged.
REQ-036 Clears: new_game asserted with a simultaneous valid move -> all outputs zero next cycle; rst mid-game -> all outputs zero next cycle.
